// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM.
// State codes, opcodes and datapath mux/ALU select values.
package controle_pkg;

    localparam logic [3:0] S_FETCH    = 4'b0000;
    localparam logic [3:0] S_DECODE   = 4'b0001;
    localparam logic [3:0] S_MEMADR   = 4'b0010;
    localparam logic [3:0] S_MEMREAD  = 4'b0011;
    localparam logic [3:0] S_MEMWB    = 4'b0100;
    localparam logic [3:0] S_MEMWRITE = 4'b0101;
    localparam logic [3:0] S_EXECR    = 4'b0110;
    localparam logic [3:0] S_ALUWB    = 4'b0111;
    localparam logic [3:0] S_EXECI    = 4'b1000;
    localparam logic [3:0] S_BEQ      = 4'b1001;
    localparam logic [3:0] S_TRAP     = 4'b1111;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_OLDPC = 2'b01;
    localparam logic [1:0] A_RS1   = 2'b10;

    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // States whose exit edge retires an instruction.
    function automatic logic is_retire(input logic [3:0] s);
        return (s == S_MEMWB) || (s == S_MEMWRITE) ||
               (s == S_ALUWB) || (s == S_BEQ);
    endfunction

endpackage

// File: rtl/controle_decod.sv
// Moore decode of the FSM state into datapath strobes and selects.
// With ILLEGAL_TRAP_EN the TRAP state raises the illegal flag.
module controle_decod
    import controle_pkg::*;
(
    input  logic [3:0] estado,
    input  logic       halt,
    output logic       irwrite,
    output logic       pcupdate,
    output logic       branch,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] resultsrc,
    output logic       illegal
);

    always_comb begin
        irwrite   = 1'b0;
        pcupdate  = 1'b0;
        branch    = 1'b0;
        regwrite  = 1'b0;
        memread   = 1'b0;
        memwrite  = 1'b0;
        alusrca   = A_PC;
        alusrcb   = B_RS2;
        aluop     = ALU_ADD;
        resultsrc = RES_ALUOUT;
        case (estado)
            S_FETCH: begin
                irwrite   = !halt;
                pcupdate  = !halt;
                alusrca   = A_PC;
                alusrcb   = B_FOUR;
                resultsrc = RES_ALU;
            end
            S_DECODE: begin
                alusrca = A_OLDPC;
                alusrcb = B_IMM;
            end
            S_MEMADR: begin
                alusrca = A_RS1;
                alusrcb = B_IMM;
            end
            S_MEMREAD:  memread = 1'b1;
            S_MEMWB: begin
                regwrite  = 1'b1;
                resultsrc = RES_MEM;
            end
            S_MEMWRITE: memwrite = 1'b1;
            S_EXECR: begin
                alusrca = A_RS1;
                aluop   = ALU_FUNCT;
            end
            S_EXECI: begin
                alusrca = A_RS1;
                alusrcb = B_IMM;
                aluop   = ALU_FUNCT;
            end
            S_ALUWB:    regwrite = 1'b1;
            S_BEQ: begin
                alusrca = A_RS1;
                aluop   = ALU_SUB;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (estado == S_TRAP);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: state register, next state, retire counter.
// Optional ILLEGAL_TRAP_EN parks illegal opcodes in a TRAP state.
module controle_multiciclo
    import controle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             halt,
    output logic [3:0]       estado,
    output logic             pcwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic             memread,
    output logic             memwrite,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [1:0]       aluop,
    output logic [1:0]       resultsrc,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    logic [3:0] next;
    logic       d_irwrite;
    logic       d_pcupdate;
    logic       d_branch;
    logic       d_regwrite;
    logic       d_memread;
    logic       d_memwrite;

    always_ff @(posedge clk) begin
        if (!rst_n) estado <= S_FETCH;
        else        estado <= next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)                instret <= '0;
        else if (is_retire(estado)) instret <= instret + 1'b1;
    end

    always_comb begin
        next = S_FETCH;
        case (estado)
            S_FETCH:    next = halt ? S_FETCH : S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_R:         next = S_EXECR;
                    OP_I:         next = S_EXECI;
                    OP_BEQ:       next = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                    default:      next = S_TRAP;
`else
                    default:      next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next = S_MEMWB;
            S_EXECR:    next = S_ALUWB;
            S_EXECI:    next = S_ALUWB;
`ifdef ILLEGAL_TRAP_EN
            S_TRAP:     next = S_TRAP;
`endif
            default:    next = S_FETCH;
        endcase
    end

    controle_decod u_decod (
        .estado    (estado),
        .halt      (halt),
        .irwrite   (d_irwrite),
        .pcupdate  (d_pcupdate),
        .branch    (d_branch),
        .regwrite  (d_regwrite),
        .memread   (d_memread),
        .memwrite  (d_memwrite),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .aluop     (aluop),
        .resultsrc (resultsrc),
        .illegal   (illegal)
    );

    // Side-effecting strobes are blocked while reset is held.
    assign irwrite  = rst_n & d_irwrite;
    assign pcwrite  = rst_n & (d_pcupdate | (d_branch & zero));
    assign regwrite = rst_n & d_regwrite;
    assign memread  = rst_n & d_memread;
    assign memwrite = rst_n & d_memwrite;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed test of the multicycle control FSM.
// Covers lw/sw/R/I/beq, halt, reset, illegal opcode, counter wrap.
module tb_controle_multiciclo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'b0000011;
    logic        zero = 1'b0;
    logic        halt = 1'b0;
    logic [3:0]  estado;
    logic        pcwrite, irwrite, regwrite, memread, memwrite;
    logic [1:0]  alusrca, alusrcb, aluop, resultsrc;
    logic [31:0] instret;
    logic        illegal;

    logic        rst2 = 1'b0;
    logic [3:0]  estado2;
    logic        pcwrite2, irwrite2, regwrite2, memread2, memwrite2;
    logic [1:0]  alusrca2, alusrcb2, aluop2, resultsrc2;
    logic [2:0]  instret2;
    logic        illegal2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    controle_multiciclo #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .halt(halt), .estado(estado), .pcwrite(pcwrite),
        .irwrite(irwrite), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .aluop(aluop), .resultsrc(resultsrc), .instret(instret),
        .illegal(illegal)
    );

    controle_multiciclo #(.CNT_W(3)) dut_w (
        .clk(clk), .rst_n(rst2), .opcode(7'b1100011), .zero(1'b0),
        .halt(1'b0), .estado(estado2), .pcwrite(pcwrite2),
        .irwrite(irwrite2), .regwrite(regwrite2), .memread(memread2),
        .memwrite(memwrite2), .alusrca(alusrca2), .alusrcb(alusrcb2),
        .aluop(aluop2), .resultsrc(resultsrc2), .instret(instret2),
        .illegal(illegal2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        check("rst_estado", {28'd0, estado}, 32'h0);
        check("rst_instret", instret, 32'h0);
        check("rst_irwrite", {31'd0, irwrite}, 32'h0);
        check("rst_pcwrite", {31'd0, pcwrite}, 32'h0);
        check("rst_illegal", {31'd0, illegal}, 32'h0);

        // lw
        rst_n = 1'b1;
        #1;
        check("fetch_irwrite", {31'd0, irwrite}, 32'h1);
        check("fetch_pcwrite", {31'd0, pcwrite}, 32'h1);
        check("fetch_srcb", {30'd0, alusrcb}, 32'h2);
        check("fetch_res", {30'd0, resultsrc}, 32'h2);
        step();
        check("lw_decode", {28'd0, estado}, 32'h1);
        check("dec_srca", {30'd0, alusrca}, 32'h1);
        check("dec_srcb", {30'd0, alusrcb}, 32'h1);
        check("dec_irwrite", {31'd0, irwrite}, 32'h0);
        step();
        check("lw_memadr", {28'd0, estado}, 32'h2);
        check("memadr_srca", {30'd0, alusrca}, 32'h2);
        check("memadr_memread", {31'd0, memread}, 32'h0);
        step();
        check("lw_memread_st", {28'd0, estado}, 32'h3);
        check("lw_memread", {31'd0, memread}, 32'h1);
        check("lw_memread_res", {30'd0, resultsrc}, 32'h0);
        step();
        check("lw_memwb", {28'd0, estado}, 32'h4);
        check("memwb_regwrite", {31'd0, regwrite}, 32'h1);
        check("memwb_memread", {31'd0, memread}, 32'h0);
        check("memwb_res", {30'd0, resultsrc}, 32'h1);
        check("lw_instret_pre", instret, 32'h0);
        step();
        check("lw_fetch", {28'd0, estado}, 32'h0);
        check("lw_instret", instret, 32'h1);

        // sw
        opcode = 7'b0100011;
        step();
        check("sw_decode", {28'd0, estado}, 32'h1);
        step();
        check("sw_memadr", {28'd0, estado}, 32'h2);
        check("sw_memadr_mw", {31'd0, memwrite}, 32'h0);
        step();
        check("sw_memwrite_st", {28'd0, estado}, 32'h5);
        check("sw_memwrite", {31'd0, memwrite}, 32'h1);
        check("sw_regwrite", {31'd0, regwrite}, 32'h0);
        check("sw_memread", {31'd0, memread}, 32'h0);
        step();
        check("sw_fetch", {28'd0, estado}, 32'h0);
        check("sw_instret", instret, 32'h2);

        // beq taken
        opcode = 7'b1100011;
        step();
        step();
        check("beq_state", {28'd0, estado}, 32'h9);
        zero = 1'b1;
        #1;
        check("beq_taken_pcw", {31'd0, pcwrite}, 32'h1);
        check("beq_aluop", {30'd0, aluop}, 32'h1);
        step();
        check("beq1_instret", instret, 32'h3);
        zero = 1'b0;
        step();
        step();
        check("beq2_state", {28'd0, estado}, 32'h9);
        check("beq_nt_pcw", {31'd0, pcwrite}, 32'h0);
        step();
        check("beq2_instret", instret, 32'h4);

        // halt in FETCH
        halt = 1'b1;
        #1;
        check("halt_irwrite", {31'd0, irwrite}, 32'h0);
        check("halt_pcwrite", {31'd0, pcwrite}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_hold", {28'd0, estado}, 32'h0);
        end
        halt = 1'b0;
        opcode = 7'b0110011;
        step();
        check("halt_release", {28'd0, estado}, 32'h1);

        // reset during EXECR
        step();
        check("r_execr", {28'd0, estado}, 32'h6);
        check("r_aluop", {30'd0, aluop}, 32'h2);
        check("r_srcb", {30'd0, alusrcb}, 32'h0);
        rst_n = 1'b0;
        step();
        check("rst_mid_estado", {28'd0, estado}, 32'h0);
        check("rst_mid_instret", instret, 32'h0);
        rst_n = 1'b1;

        // I-type
        opcode = 7'b0010011;
        step();
        step();
        check("i_execi", {28'd0, estado}, 32'h8);
        check("i_srcb", {30'd0, alusrcb}, 32'h1);
        step();
        check("i_aluwb", {28'd0, estado}, 32'h7);
        check("i_regwrite", {31'd0, regwrite}, 32'h1);
        step();
        check("i_instret", instret, 32'h1);

        // illegal opcode
        opcode = 7'b1111111;
        step();
        step();
`ifdef ILLEGAL_TRAP_EN
        check("ill_trap", {28'd0, estado}, 32'hf);
        check("ill_flag", {31'd0, illegal}, 32'h1);
        step();
        step();
        check("ill_hold", {28'd0, estado}, 32'hf);
        check("ill_flag_hold", {31'd0, illegal}, 32'h1);
`else
        check("ill_nop", {28'd0, estado}, 32'h0);
        check("ill_flag", {31'd0, illegal}, 32'h0);
`endif
        check("ill_instret", instret, 32'h1);

        // counter wrap on a narrow instance
        check("w_rst", {29'd0, instret2}, 32'h0);
        rst2 = 1'b1;
        repeat (21) step();
        check("w_seven", {29'd0, instret2}, 32'h7);
        repeat (3) step();
        check("w_wrap", {29'd0, instret2}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
